seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width; derived, not overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  block accepts operation this cycle.
REQ-007 a, b  input  WIDTH  operands.
REQ-008 aluop  input  4  operation select.
REQ-009 out_valid  output  1  result registered and held.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  WIDTH  operation result.
REQ-012 zero  output  1  result == 0.
REQ-013 ovf  output  1  signed overflow (ADD/SUB only, else 0).
REQ-014 err  output  1  aluop was an unassigned code.

Function
REQ-015 Opcodes: 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0110 XOR, 0111 NOR, 1000 SLL, 1001 SRL, 1100 SRA, 1010 SLT (signed), 1011 SLTU, 1110 MUL (low WIDTH bits of a*b); all other codes unassigned.
REQ-016 Accept = in_valid & in_ready; operands and aluop are captured on accept; later input changes have no effect on that operation.
REQ-017 State machine IDLE, BUSY, HOLD; reset enters IDLE.
REQ-018 IDLE: in_ready=1; on accept of a non-MUL op: compute, register result/flags, go HOLD; on accept of MUL: go BUSY.
REQ-019 BUSY: in_ready=0; iterative shift-add multiply, one bit of b per cycle, exactly WIDTH cycles; after the last iteration, register result, go HOLD.
REQ-020 HOLD: out_valid=1, result/zero/ovf/err stable; on out_ready go IDLE; in_ready=out_ready (new op accepted in the same cycle the result drains, giving back-to-back throughput).
REQ-021 Latency: non-MUL out_valid asserts the cycle after accept; MUL out_valid asserts WIDTH+1 cycles after accept.
REQ-022 SLT compares signed a<b using the true signed comparison (no reliance on the MSB of a wrapped difference); result is 1 or 0, zero-extended.
REQ-023 SLTU is an unsigned compare with the same 1/0 result format.
REQ-024 Shifts use b[SHW-1:0] as the amount; the upper bits of b are ignored; shift amount 0 returns a; SRA sign-fills.
REQ-025 ADD/SUB wrap modulo 2^WIDTH; ovf=1 when the operand signs imply the result sign is wrong.
REQ-026 Unassigned opcode: accepted normally, 1-cycle latency, result=0, zero=1, err=1.
REQ-027 zero, ovf, and err are registered alongside result; no combinational path from a/b to any output.
REQ-028 in_valid while BUSY, or in HOLD without out_ready, is ignored; the producer holds.

Reset
REQ-029 reset asserted at any time, including mid-BUSY or in HOLD, immediately forces IDLE, out_valid=0, result=0, zero=0, ovf=0, err=0, in_ready=1 after release; the in-flight operation is discarded.
REQ-030 The first accept may occur in the first rising edge after reset deassertion.

Verification (WIDTH=32)
REQ-031 ADD a=0x7FFFFFFF b=1 -> next cycle out_valid=1, result=0x80000000, ovf=1, zero=0.
REQ-032 SLT a=0x80000000 b=1 -> result=1. SLTU with the same operands -> result=0. SLT a=0x7FFFFFFF b=0xFFFFFFFF -> result=0.
REQ-033 MUL a=0xFFFF b=0x10001 -> in_ready=0 for 32 cycles; out_valid at cycle 33; result=0xFFFFFFFF.
REQ-034 SRA a=0x80000000 b=0x00000021 -> amount 1, result=0xC0000000. aluop=1111 -> result=0, zero=1, err=1.
REQ-035 Result held with out_ready=0 for 5 cycles -> result stable, in_ready=0. Then out_ready=1 with a new in_valid -> both complete the same cycle; the next result follows one cycle later.
REQ-036 reset pulsed at BUSY cycle 10 of MUL -> out_valid=0, result=0; a subsequent ADD 2+3 returns 5 with no residue from the aborted multiply.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: registered-result ALU with a one-operation-at-a-time valid/ready
// handshake. Single-cycle ops land in HOLD one cycle after accept; MUL runs
// an iterative shift-add over WIDTH cycles in BUSY before landing in HOLD.
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       aluop,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             ovf,
   output logic             err
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b0101;
   localparam logic [3:0] OP_XOR  = 4'b0110;
   localparam logic [3:0] OP_NOR  = 4'b0111;
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_SLT  = 4'b1010;
   localparam logic [3:0] OP_SLTU = 4'b1011;
   localparam logic [3:0] OP_SRA  = 4'b1100;
   localparam logic [3:0] OP_MUL  = 4'b1110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] mcand_reg;   // multiplicand, shifted left each iteration
   logic [WIDTH-1:0] mplier_reg;  // multiplier, shifted right each iteration
   logic [WIDTH-1:0] acc_reg;     // running partial product (low WIDTH bits)
   logic [SHW-1:0]   count_reg;   // iterations completed so far

   logic             accept;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] alu_result;
   logic             alu_ovf;
   logic             alu_err;
   logic [WIDTH-1:0] acc_next;

   // HOLD accepts a new op in the same cycle its result drains
   assign in_ready  = (state_reg == IDLE) || ((state_reg == HOLD) && out_ready);
   assign out_valid = (state_reg == HOLD);
   assign accept    = in_valid && in_ready;

   assign sum   = a + b;
   assign diff  = a - b;
   assign shamt = b[SHW-1:0];

   // Shift-add step: add the multiplicand when the current multiplier bit is set
   assign acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

   // Single-cycle datapath evaluated on the live inputs; only sampled on accept
   always_comb begin
      alu_result = '0;
      alu_ovf    = 1'b0;
      alu_err    = 1'b0;
      case (aluop)
         OP_ADD: begin
            alu_result = sum;
            alu_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_result = diff;
            alu_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  alu_result = a & b;
         OP_OR:   alu_result = a | b;
         OP_XOR:  alu_result = a ^ b;
         OP_NOR:  alu_result = ~(a | b);
         OP_SLL:  alu_result = a << shamt;
         OP_SRL:  alu_result = a >> shamt;
         OP_SRA:  alu_result = $signed(a) >>> shamt;
         OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_MUL:  alu_result = '0;  // produced by the iterative path instead
         default: alu_err    = 1'b1;
      endcase
   end

   // Control FSM plus result/flag registers and the iterative multiplier state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= IDLE;
         result     <= '0;
         zero       <= 1'b0;
         ovf        <= 1'b0;
         err        <= 1'b0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         acc_reg    <= '0;
         count_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE, HOLD: begin
               if (accept) begin
                  if (aluop == OP_MUL) begin
                     mcand_reg  <= a;
                     mplier_reg <= b;
                     acc_reg    <= '0;
                     count_reg  <= '0;
                     state_reg  <= BUSY;
                  end else begin
                     result    <= alu_result;
                     zero      <= (alu_result == '0);
                     ovf       <= alu_ovf;
                     err       <= alu_err;
                     state_reg <= HOLD;
                  end
               end else if (state_reg == HOLD && out_ready) begin
                  state_reg <= IDLE;
               end
            end
            BUSY: begin
               acc_reg    <= acc_next;
               mcand_reg  <= mcand_reg << 1;
               mplier_reg <= mplier_reg >> 1;
               count_reg  <= count_reg + SHW'(1);
               if (count_reg == SHW'(WIDTH - 1)) begin
                  result    <= acc_next;
                  zero      <= (acc_next == '0);
                  ovf       <= 1'b0;
                  err       <= 1'b0;
                  state_reg <= HOLD;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu (WIDTH=32): directed corner cases plus randomized
// traffic, checked by a scoreboard fed from an arithmetic reference model.
module tb_seq_alu;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  aluop;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        ovf;
   logic        err;

   typedef struct {
      logic [31:0] r;
      logic        z;
      logic        o;
      logic        e;
   } exp_t;

   exp_t sb_q[$];
   int   n_vectors = 0;
   int   n_cmp     = 0;
   int   n_fail    = 0;
   logic rand_mode   = 1'b0;
   logic forced_ready = 1'b0;
   logic [31:0] specials [6] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
                                 32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_001F};

   seq_alu #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .aluop     (aluop),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .ovf       (ovf),
      .err       (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: plain signed/unsigned arithmetic on 64-bit integers
   function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      exp_t   e;
      longint sx = longint'($signed(x));
      longint sy = longint'($signed(y));
      longint ux = longint'({32'b0, x});
      longint uy = longint'({32'b0, y});
      longint full;
      int     amt = int'(y % 32);
      e.r = 32'h0; e.o = 1'b0; e.e = 1'b0;
      case (op)
         4'b0000: begin full = sx + sy; e.r = 32'(full);
                  e.o = (full > 64'sd2147483647) || (full < -64'sd2147483648); end
         4'b0010: begin full = sx - sy; e.r = 32'(full);
                  e.o = (full > 64'sd2147483647) || (full < -64'sd2147483648); end
         4'b0100: e.r = x & y;
         4'b0101: e.r = x | y;
         4'b0110: e.r = x ^ y;
         4'b0111: e.r = ~(x | y);
         4'b1000: e.r = 32'(ux * (64'sd1 <<< amt));
         4'b1001: e.r = 32'(ux / (64'sd1 <<< amt));
         4'b1100: e.r = 32'(sx >>> amt);
         4'b1010: e.r = (sx < sy) ? 32'd1 : 32'd0;
         4'b1011: e.r = (ux < uy) ? 32'd1 : 32'd0;
         4'b1110: e.r = 32'(ux * uy);
         default: e.e = 1'b1;
      endcase
      e.z = (e.r == 32'h0);
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present an op and wait (bounded) for the accept edge; returns at edge+1
   task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        output int waited);
      in_valid = 1'b1; aluop = op; a = x; b = y; waited = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         waited++;
         if (waited > 200) break;
      end
      if (waited > 200) begin
         n_cmp++; n_fail++;
         $display("FAIL accept_timeout: op %0h never accepted", op);
      end else begin
         sb_q.push_back(model(op, x, y));
         n_vectors++;
      end
      step();
      in_valid = 1'b0;
      a = $urandom; b = $urandom; aluop = 4'($urandom);
   endtask

   function automatic logic [31:0] pick();
      if ($urandom_range(3) == 0) return specials[$urandom_range(5)];
      return $urandom;
   endfunction

   // Consumer: out_ready is either random or forced by the directed sequence
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         out_ready = rand_mode ? ($urandom_range(3) != 0) : forced_ready;
      end
   end

   // Monitor: compare every presented result against the scoreboard head
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            sb_q.delete();
         end else if (out_valid) begin
            if (sb_q.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL unexpected_output: result %0h with empty scoreboard", result);
            end else begin
               e = sb_q[0];
               chk("sb_result", result, e.r);
               chk("sb_zero", zero, e.z);
               chk("sb_ovf", ovf, e.o);
               chk("sb_err", err, e.e);
               chk("hold_in_ready", in_ready, out_ready);
               $display("txn result=%08h zero=%0b ovf=%0b err=%0b drained=%0b",
                        result, zero, ovf, err, out_ready);
               if (out_ready) void'(sb_q.pop_front());
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   // Stimulus
   initial begin
      int w;
      int n;
      int busy_low;
      logic [3:0] op;
      reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; aluop = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_zero", zero, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_err", err, 0);
      chk("rst_in_ready", in_ready, 1);
      step();
      reset = 1'b0;
      forced_ready = 1'b1;

      // First accept on the first edge after release; ADD overflow corner
      issue(4'b0000, 32'h7FFF_FFFF, 32'h1, w);
      chk("first_accept_wait", w, 0);
      @(negedge clk);
      chk("add_latency_valid", out_valid, 1);
      chk("add_result", result, 32'h8000_0000);
      chk("add_ovf", ovf, 1);
      chk("add_zero", zero, 0);
      step();

      issue(4'b1010, 32'h8000_0000, 32'h1, w);
      issue(4'b1011, 32'h8000_0000, 32'h1, w);
      issue(4'b1010, 32'h7FFF_FFFF, 32'hFFFF_FFFF, w);
      issue(4'b0010, 32'h8000_0000, 32'h1, w);
      issue(4'b1100, 32'h8000_0000, 32'h21, w);
      issue(4'b1000, 32'h1234_5678, 32'hFFFF_FFE0, w);
      issue(4'b1111, 32'hDEAD_BEEF, 32'h1, w);
      @(negedge clk);
      chk("unassigned_result", result, 0);
      chk("unassigned_zero", zero, 1);
      chk("unassigned_err", err, 1);
      step();

      // MUL latency, busy window, then a 5-cycle held result
      issue(4'b1110, 32'h0000_FFFF, 32'h0001_0001, w);
      forced_ready = 1'b0;
      n = 0; busy_low = 0;
      forever begin
         @(negedge clk);
         n++;
         if (out_valid || n > 100) break;
         if (!in_ready) busy_low++;
      end
      chk("mul_latency", n, 33);
      chk("mul_busy_cycles", busy_low, 32);
      chk("mul_result", result, 32'hFFFF_FFFF);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_stall_in_ready", in_ready, 0);
         chk("hold_stall_result", result, 32'hFFFF_FFFF);
      end
      step();
      forced_ready = 1'b1;
      issue(4'b0000, 32'd10, 32'd20, w);
      chk("b2b_accept_wait", w, 0);
      @(negedge clk);
      chk("b2b_next_valid", out_valid, 1);
      chk("b2b_next_result", result, 32'd30);
      step();

      // Reset at BUSY cycle 10 discards the multiply
      issue(4'b1110, 32'h1357_9BDF, 32'h2468_ACE0, w);
      repeat (10) @(negedge clk);
      step();
      reset = 1'b1;
      @(negedge clk);
      chk("midmul_rst_out_valid", out_valid, 0);
      chk("midmul_rst_result", result, 0);
      chk("midmul_rst_in_ready", in_ready, 1);
      step();
      reset = 1'b0;
      issue(4'b0000, 32'd2, 32'd3, w);
      @(negedge clk);
      chk("post_rst_valid", out_valid, 1);
      chk("post_rst_add", result, 32'd5);
      step();

      // Randomized traffic with a random consumer
      rand_mode = 1'b1;
      for (int i = 0; i < 200; i++) begin
         op = 4'($urandom);
         if (op == 4'b1110 && $urandom_range(2) != 0) op = 4'b0000;
         if ($urandom_range(3) == 0) step();
         issue(op, pick(), pick(), w);
      end
      rand_mode = 1'b0;
      forced_ready = 1'b1;
      n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drained", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_fail);
      $finish;
   end

endmodule
